regfile_write_queue: RTL and testbench

Write-side companion to the 32×32 register file: accepts register writeback requests from the execute/memory stages, buffers them in a small in-order queue, and drains one entry per cycle onto the register file write port (RW, BusW, RegWr). It also provides a bypass lookup so readers see the newest pending value for a register before it is committed. It sits between the writeback mux and the register file.

---
 rtl/regfile_write_queue.sv | 96 +++++++++
 tb/tb_regfile_write_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// In-order writeback queue in front of the 32x32 register file: buffers requests,
// drains one per cycle onto RW/BusW/RegWr, and offers a newest-value bypass lookup.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        WbValid,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  output logic        WbReady,
  input  logic        Hold,
  output logic [4:0]  RW,
  output logic [31:0] BusW,
  output logic        RegWr,
  input  logic [4:0]  LookupReg,
  output logic        LookupHit,
  output logic [31:0] LookupData,
  output logic        Idle
);

  logic [4:0]      entryReg  [DEPTH];
  logic [31:0]     entryData [DEPTH];
  logic [PTRW-1:0] wrPtr, rdPtr;
  logic [PTRW:0]   count;

  logic accept, push, pop;

  // Ready depends on occupancy only, so a full queue refuses even while popping.
  assign WbReady = (count != (PTRW+1)'(DEPTH));
  assign accept  = WbValid && WbReady;
  assign push    = accept && (WbReg != 5'd0);
  assign pop     = (count != '0) && !Hold;
  assign Idle    = (count == '0) && !RegWr;

  // NOTE: storage has no reset; only pointers and count define which entries are
  // valid, so stale contents are never observed and the array stays a plain RAM.
  always_ff @(posedge Clk) begin
    if (push) begin
      entryReg[wrPtr]  <= WbReg;
      entryData[wrPtr] <= WbData;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every read in this
  // block sees pre-edge values (the pop takes the old head even when count==1).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      RegWr <= 1'b0;
      RW    <= 5'd0;
      BusW  <= 32'd0;
    end else begin
      if (push) wrPtr <= wrPtr + PTRW'(1);
      if (pop) begin
        RW    <= entryReg[rdPtr];
        BusW  <= entryData[rdPtr];
        RegWr <= 1'b1;
        rdPtr <= rdPtr + PTRW'(1);
      end else begin
        RegWr <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Scan oldest to youngest so later matches override earlier ones; the output
  // stage is older than anything still queued.
  // NOTE: both outputs get a default before any condition, so no latch is inferred.
  always_comb begin
    LookupHit  = 1'b0;
    LookupData = 32'd0;
    if (RegWr && (RW == LookupReg)) begin
      LookupHit  = 1'b1;
      LookupData = BusW;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTRW+1)'(i) < count) && (entryReg[rdPtr + PTRW'(i)] == LookupReg)) begin
        LookupHit  = 1'b1;
        LookupData = entryData[rdPtr + PTRW'(i)];
      end
    end
    if (LookupReg == 5'd0) begin
      LookupHit  = 1'b0;
      LookupData = 32'd0;
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_regfile_write_queue;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        WbValid = 1'b0;
  logic [4:0]  WbReg = 5'd0;
  logic [31:0] WbData = 32'd0;
  logic        WbReady;
  logic        Hold = 1'b0;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        RegWr;
  logic [4:0]  LookupReg = 5'd0;
  logic        LookupHit;
  logic [31:0] LookupData;
  logic        Idle;

  regfile_write_queue #(.DEPTH(DEPTH), .PTRW(2)) dut (
    .Clk(Clk), .Reset(Reset), .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
    .WbReady(WbReady), .Hold(Hold), .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData), .Idle(Idle)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  // Reference model: pending writes in arrival order plus the committed output stage.
  wr_t         pending[$];
  logic        mRegWr = 1'b0;
  logic [4:0]  mRW = 5'd0;
  logic [31:0] mBusW = 32'd0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] lookupModel(input logic [4:0] r);
    if (r == 5'd0) return 33'd0;
    for (int i = pending.size() - 1; i >= 0; i--)
      if (pending[i].r == r) return {1'b1, pending[i].d};
    if (mRegWr && mRW == r) return {1'b1, mBusW};
    return 33'd0;
  endfunction

  // Apply the behavioural rules for one clock edge using the inputs now applied.
  task automatic modelEdge();
    bit  ready;
    wr_t head;
    ready = (pending.size() != DEPTH);
    if (Reset) begin
      pending.delete();
      mRegWr = 1'b0;
      mRW    = 5'd0;
      mBusW  = 32'd0;
    end else begin
      if (pending.size() > 0 && !Hold) begin
        head   = pending.pop_front();
        mRegWr = 1'b1;
        mRW    = head.r;
        mBusW  = head.d;
      end else begin
        mRegWr = 1'b0;
      end
      if (WbValid && ready && WbReg != 5'd0) pending.push_back({WbReg, WbData});
    end
  endtask

  task automatic checkAll(input string tag);
    logic [32:0] lk;
    lk = lookupModel(LookupReg);
    chk({tag, ".WbReady"},    {31'd0, WbReady},   {31'd0, pending.size() != DEPTH});
    chk({tag, ".RegWr"},      {31'd0, RegWr},     {31'd0, mRegWr});
    chk({tag, ".RW"},         {27'd0, RW},        {27'd0, mRW});
    chk({tag, ".BusW"},       BusW,               mBusW);
    chk({tag, ".Idle"},       {31'd0, Idle},      {31'd0, (pending.size() == 0) && !mRegWr});
    chk({tag, ".LookupHit"},  {31'd0, LookupHit}, {31'd0, lk[32]});
    chk({tag, ".LookupData"}, LookupData,         lk[31:0]);
  endtask

  task automatic step(input string tag);
    modelEdge();
    @(posedge Clk);
    #1;
    checkAll(tag);
  endtask

  task automatic setReq(input logic v, input logic [4:0] r, input logic [31:0] d);
    WbValid = v;
    WbReg   = r;
    WbData  = d;
  endtask

  initial begin
    // Reset then idle
    step("rst0");
    step("rst1");
    Reset = 1'b0;
    chk("rst.WbReady", {31'd0, WbReady}, 32'd1);
    chk("rst.RegWr",   {31'd0, RegWr},   32'd0);
    chk("rst.BusW",    BusW,             32'd0);
    chk("rst.Idle",    {31'd0, Idle},    32'd1);

    // Single write
    LookupReg = 5'd5;
    setReq(1'b1, 5'd5, 32'hDEADBEEF);
    step("single1");
    setReq(1'b0, 5'd0, 32'd0);
    chk("single.hitQueued", LookupData, 32'hDEADBEEF);
    step("single2");
    chk("single.RW", {27'd0, RW}, 32'd5);
    chk("single.BusW", BusW, 32'hDEADBEEF);
    step("single3");
    chk("single.idleAfter", {31'd0, Idle}, 32'd1);

    // Fill with Hold, stalled 5th request, then release
    Hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      setReq(1'b1, 5'(i), 32'(i * 32'h11));
      step("fill");
    end
    chk("fill.notReady", {31'd0, WbReady}, 32'd0);
    setReq(1'b1, 5'd9, 32'h55);
    step("stall");
    Hold = 1'b0;
    step("rel1");
    chk("rel1.RW", {27'd0, RW}, 32'd1);
    for (int i = 0; i < 5; i++) step("drain");
    setReq(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) step("drainIdle");

    // Same-register ordering and bypass
    LookupReg = 5'd7;
    Hold = 1'b1;
    setReq(1'b1, 5'd7, 32'hA);
    step("same1");
    setReq(1'b1, 5'd7, 32'hB);
    step("same2");
    setReq(1'b0, 5'd0, 32'd0);
    chk("same.newest", LookupData, 32'hB);
    Hold = 1'b0;
    for (int i = 0; i < 4; i++) step("sameDrain");

    // Register 0 is consumed but never queued
    LookupReg = 5'd0;
    setReq(1'b1, 5'd0, 32'hFFFF_FFFF);
    step("r0");
    setReq(1'b0, 5'd0, 32'd0);
    step("r0b");
    chk("r0.noWrite", {31'd0, RegWr}, 32'd0);

    // Reset mid-operation discards queued writes
    Hold = 1'b1;
    LookupReg = 5'd3;
    for (int i = 0; i < 3; i++) begin
      setReq(1'b1, 5'(i + 2), 32'hC0DE_0000 + 32'(i));
      step("midFill");
    end
    setReq(1'b0, 5'd0, 32'd0);
    Reset = 1'b1;
    step("midRst");
    Reset = 1'b0;
    Hold = 1'b0;
    chk("midRst.Idle", {31'd0, Idle}, 32'd1);
    for (int i = 0; i < 4; i++) step("midAfter");
    chk("midRst.BusW", BusW, 32'd0);

    // Random traffic with heavy register reuse
    for (int i = 0; i < 400; i++) begin
      setReq($urandom_range(9, 0) < 7, 5'($urandom_range(7, 0)), $urandom);
      Hold      = ($urandom_range(9, 0) < 3);
      LookupReg = 5'($urandom_range(7, 0));
      Reset     = ($urandom_range(63, 0) == 0);
      #1;
      checkAll("randPre");
      step("rand");
    end
    Reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
